// File: rtl/codificador_hamming_tx.sv
// Purpose: Hamming(7,4)+overall-parity (SECDED) encoder feeding a start/8-data/stop serial transmitter.
// Latency: the line drops to the start bit on the accept edge; fin pulses 10*CICLOS_POR_BIT cycles after accept.
// Backpressure: listo=0 for the whole frame; valido_in while busy is dropped (no queueing).
// Optional feature: define INYECCION_ERROR_EN to add mascara_err[7:0], XORed into the captured code word.
module codificador_hamming_tx #(
    parameter int CICLOS_POR_BIT = 16,
    parameter int LSB_PRIMERO    = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] dato_in,
    input  logic       valido_in,
`ifdef INYECCION_ERROR_EN
    input  logic [7:0] mascara_err,
`endif
    output logic       listo,
    output logic [7:0] palabra_cod,
    output logic       tx_serial,
    output logic       tx_activo,
    output logic       fin
);

    localparam int CW = $clog2(CICLOS_POR_BIT + 1);
    localparam logic [CW-1:0] ULTIMO = CW'(CICLOS_POR_BIT - 1);

    typedef enum logic [1:0] {IDLE, INICIO, DATOS, PARADA} estado_t;

    estado_t       estado, estado_sig;
    logic [CW-1:0] cnt, cnt_sig;
    logic [2:0]    bit_cnt, bit_sig;
    logic          tx_sig, fin_sig;
    logic [7:0]    palabra_sig;
    logic [7:0]    palabra;
    logic [7:0]    palabra_cap;
    logic          p0, p1, p2, g0;

    // Serial order: bit i of the frame payload, counted from whichever end goes first
    function automatic logic bit_de(input logic [7:0] w, input logic [2:0] i);
        return (LSB_PRIMERO != 0) ? w[i] : w[3'd7 - i];
    endfunction

    // Encoder: three Hamming parities over the data, then even parity over the 7-bit word
    always_comb begin
        p0 = dato_in[0] ^ dato_in[1] ^ dato_in[3];
        p1 = dato_in[0] ^ dato_in[2] ^ dato_in[3];
        p2 = dato_in[1] ^ dato_in[2] ^ dato_in[3];
        g0 = ^{dato_in[3], dato_in[2], dato_in[1], p2, dato_in[0], p1, p0};
        palabra = {g0, dato_in[3], dato_in[2], dato_in[1], p2, dato_in[0], p1, p0};
`ifdef INYECCION_ERROR_EN
        palabra_cap = palabra ^ mascara_err;
`else
        palabra_cap = palabra;
`endif
    end

    assign listo     = (estado == IDLE);
    assign tx_activo = (estado != IDLE);

    // Next-state and next-output logic; line value is registered so it never glitches
    always_comb begin
        estado_sig  = estado;
        cnt_sig     = cnt;
        bit_sig     = bit_cnt;
        tx_sig      = tx_serial;
        fin_sig     = 1'b0;
        palabra_sig = palabra_cod;
        case (estado)
            IDLE: begin
                tx_sig  = 1'b1;
                cnt_sig = '0;
                bit_sig = '0;
                if (valido_in) begin
                    palabra_sig = palabra_cap;
                    tx_sig      = 1'b0;
                    estado_sig  = INICIO;
                end
            end
            INICIO: begin
                if (cnt == ULTIMO) begin
                    cnt_sig    = '0;
                    bit_sig    = '0;
                    tx_sig     = bit_de(palabra_cod, 3'd0);
                    estado_sig = DATOS;
                end else begin
                    cnt_sig = cnt + 1'b1;
                end
            end
            DATOS: begin
                if (cnt == ULTIMO) begin
                    cnt_sig = '0;
                    if (bit_cnt == 3'd7) begin
                        bit_sig    = '0;
                        tx_sig     = 1'b1;
                        estado_sig = PARADA;
                    end else begin
                        bit_sig = bit_cnt + 3'd1;
                        tx_sig  = bit_de(palabra_cod, bit_cnt + 3'd1);
                    end
                end else begin
                    cnt_sig = cnt + 1'b1;
                end
            end
            PARADA: begin
                tx_sig = 1'b1;
                if (cnt == ULTIMO) begin
                    cnt_sig    = '0;
                    fin_sig    = 1'b1;
                    estado_sig = IDLE;
                end else begin
                    cnt_sig = cnt + 1'b1;
                end
            end
            default: begin
                estado_sig = IDLE;
                tx_sig     = 1'b1;
                cnt_sig    = '0;
                bit_sig    = '0;
            end
        endcase
    end

    // State and output registers; reset aborts any frame in flight with the line high
    always_ff @(posedge clk) begin
        if (rst) begin
            estado      <= IDLE;
            cnt         <= '0;
            bit_cnt     <= '0;
            tx_serial   <= 1'b1;
            fin         <= 1'b0;
            palabra_cod <= 8'h00;
        end else begin
            estado      <= estado_sig;
            cnt         <= cnt_sig;
            bit_cnt     <= bit_sig;
            tx_serial   <= tx_sig;
            fin         <= fin_sig;
            palabra_cod <= palabra_sig;
        end
    end

endmodule

// File: tb/tb_codificador_hamming_tx.sv
// Bench for codificador_hamming_tx: two instances (1 cycle/bit LSB-first, 4 cycles/bit MSB-first),
// drivers push expected code words into per-instance queues, monitors pop and check each frame.
// Define INYECCION_ERROR_EN to also exercise the error-injection mask.
module tb_codificador_hamming_tx;

    logic            clk;
    logic [1:0]      rst, valido, listo_s, tx_s, act_s, fin_s;
    logic [1:0][3:0] dato;
    logic [1:0][7:0] pal_s;
`ifdef INYECCION_ERROR_EN
    logic [1:0][7:0] mascara;
`endif
    bit   [1:0]      abortar;
    logic [7:0]      esp0[$], esp1[$];
    int              tests = 0, fallos = 0;

    codificador_hamming_tx #(.CICLOS_POR_BIT(1), .LSB_PRIMERO(1)) dut0 (
        .clk(clk), .rst(rst[0]), .dato_in(dato[0]), .valido_in(valido[0]),
`ifdef INYECCION_ERROR_EN
        .mascara_err(mascara[0]),
`endif
        .listo(listo_s[0]), .palabra_cod(pal_s[0]), .tx_serial(tx_s[0]),
        .tx_activo(act_s[0]), .fin(fin_s[0]));

    codificador_hamming_tx #(.CICLOS_POR_BIT(4), .LSB_PRIMERO(0)) dut1 (
        .clk(clk), .rst(rst[1]), .dato_in(dato[1]), .valido_in(valido[1]),
`ifdef INYECCION_ERROR_EN
        .mascara_err(mascara[1]),
`endif
        .listo(listo_s[1]), .palabra_cod(pal_s[1]), .tx_serial(tx_s[1]),
        .tx_activo(act_s[1]), .fin(fin_s[1]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int cpb(input int d);
        return (d == 0) ? 1 : 4;
    endfunction

    // Reference encoder: each parity is the even parity of the data bits it covers
    function automatic logic [7:0] codificar(input logic [3:0] w);
        logic p0, p1, p2, g0;
        logic [6:0] b;
        p0 = ($countones(w & 4'b1011) % 2) == 1;
        p1 = ($countones(w & 4'b1101) % 2) == 1;
        p2 = ($countones(w & 4'b1110) % 2) == 1;
        b  = {w[3], w[2], w[1], p2, w[0], p1, p0};
        g0 = ($countones(b) % 2) == 1;
        return {g0, b};
    endfunction

    // Receiver model: classic position-number syndrome plus overall parity
    function automatic void recibir(input logic [7:0] c, output logic [3:0] datos, output int nerr);
        int sin;
        logic [7:0] x;
        sin = 0;
        for (int i = 1; i <= 7; i++) if (c[i-1]) sin = sin ^ i;
        x = c;
        if (^c) begin
            nerr = 1;
            if (sin != 0) x[sin-1] = ~x[sin-1];
        end else begin
            nerr = (sin != 0) ? 2 : 0;
        end
        datos = {x[6], x[5], x[4], x[2]};
    endfunction

    // Expected line level for frame bit slot j (0 = start, 9 = stop)
    function automatic logic bit_linea(input int d, input logic [7:0] c, input int j);
        if (j == 0) return 1'b0;
        if (j == 9) return 1'b1;
        return (d == 0) ? c[j-1] : c[8-j];
    endfunction

    task automatic comprobar(input string n, input logic [31:0] a, input logic [31:0] e);
        tests++;
        if (a !== e) begin
            fallos++;
            $display("FAIL %s: got %0h expected %0h", n, a, e);
        end
    endtask

    task automatic fallar(input string n);
        tests++;
        fallos++;
        $display("FAIL %s", n);
    endtask

    task automatic empujar(input int d, input logic [7:0] v);
        if (d == 0) esp0.push_back(v); else esp1.push_back(v);
    endtask

    task automatic monitor(input int d);
        logic prev;
        logic [7:0] e;
        int malos;
        bit abortado, hay;
        prev = 1'b0;
        forever begin
            @(negedge clk);
            if (fin_s[d] === 1'b1) fallar($sformatf("fin_espurio%0d", d));
            if (act_s[d] === 1'b1 && !prev) begin
                hay = (d == 0) ? (esp0.size() > 0) : (esp1.size() > 0);
                if (!hay) begin
                    fallar($sformatf("trama_sin_esperar%0d", d));
                end else begin
                    e = (d == 0) ? esp0.pop_front() : esp1.pop_front();
                    comprobar($sformatf("palabra_inicio%0d", d), pal_s[d], e);
                    malos = 0;
                    abortado = 0;
                    for (int s = 0; s < 10 * cpb(d); s++) begin
                        if (s > 0) @(negedge clk);
                        if (act_s[d] !== 1'b1 && abortar[d]) begin
                            abortar[d] = 0;
                            abortado = 1;
                            break;
                        end
                        if (tx_s[d] !== bit_linea(d, e, s / cpb(d)) || act_s[d] !== 1'b1 ||
                            listo_s[d] !== 1'b0 || fin_s[d] !== 1'b0) malos++;
                    end
                    if (!abortado) begin
                        comprobar($sformatf("linea%0d_%0h", d, e), malos, 0);
                        @(negedge clk);
                        comprobar($sformatf("fin%0d", d), fin_s[d], 1);
                        comprobar($sformatf("listo_fin%0d", d), listo_s[d], 1);
                        comprobar($sformatf("activo_fin%0d", d), act_s[d], 0);
                        comprobar($sformatf("palabra_fin%0d", d), pal_s[d], e);
                    end
                end
            end
            prev = act_s[d];
        end
    endtask

    // Drive one word when the DUT is ready; optionally poke valido_in while it is busy
    task automatic enviar(input int d, input logic [3:0] w, input logic [7:0] m,
                          input bit ocupado, output bit fue_fin);
        int espera;
        logic [3:0] dd;
        int ne;
        espera = 0;
        fue_fin = 0;
        @(negedge clk);
        while (listo_s[d] !== 1'b1) begin
            @(negedge clk);
            espera++;
            if (espera > 200) begin
                fallar($sformatf("timeout_listo%0d", d));
                return;
            end
        end
        fue_fin = fin_s[d];
        valido[d] = 1'b1;
        dato[d] = w;
`ifdef INYECCION_ERROR_EN
        mascara[d] = m;
`endif
        empujar(d, codificar(w) ^ m);
        @(posedge clk);
        @(negedge clk);
        valido[d] = 1'b0;
        dato[d] = 4'($urandom);
`ifdef INYECCION_ERROR_EN
        mascara[d] = 8'($urandom);
`endif
        if (m == 8'h00) begin
            recibir(pal_s[d], dd, ne);
            comprobar($sformatf("sindrome%0d_%0h", d, w), ne, 0);
            comprobar($sformatf("decod%0d_%0h", d, w), dd, w);
        end
        if (ocupado) begin
            repeat ($urandom_range(1, 8 * cpb(d))) @(negedge clk);
            if (listo_s[d] === 1'b0) begin
                valido[d] = 1'b1;
                dato[d] = 4'($urandom);
                @(negedge clk);
                valido[d] = 1'b0;
            end
        end
    endtask

    initial begin
        bit ff;
        rst = 2'b11;
        valido = 2'b00;
        dato = '0;
        abortar = '0;
`ifdef INYECCION_ERROR_EN
        mascara = '0;
`endif
        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            comprobar($sformatf("rst_tx%0d", d), tx_s[d], 1);
            comprobar($sformatf("rst_listo%0d", d), listo_s[d], 1);
            comprobar($sformatf("rst_activo%0d", d), act_s[d], 0);
            comprobar($sformatf("rst_fin%0d", d), fin_s[d], 0);
            comprobar($sformatf("rst_palabra%0d", d), pal_s[d], 8'h00);
        end
        rst = 2'b00;
        fork
            monitor(0);
            monitor(1);
        join_none

        fork
            begin : rama0
                enviar(0, 4'b1011, 8'h00, 0, ff);
                comprobar("T2_palabra", pal_s[0], 8'h55);
                enviar(0, 4'b0000, 8'h00, 0, ff);
                comprobar("T3_0000", pal_s[0], 8'h00);
                enviar(0, 4'b1111, 8'h00, 0, ff);
                comprobar("T3_1111", pal_s[0], 8'hFF);
                enviar(0, 4'b0001, 8'h00, 0, ff);
                comprobar("T3_0001", pal_s[0], 8'h87);
`ifdef INYECCION_ERROR_EN
                begin
                    logic [3:0] dd;
                    int ne;
                    enviar(0, 4'b1011, 8'h04, 0, ff);
                    comprobar("T6_palabra", pal_s[0], 8'h51);
                    recibir(pal_s[0], dd, ne);
                    comprobar("T6_un_error", ne, 1);
                    comprobar("T6_corregido", dd, 4'b1011);
                    enviar(0, 4'b1011, 8'h06, 0, ff);
                    recibir(pal_s[0], dd, ne);
                    comprobar("T6_dos_errores", ne, 2);
                end
`endif
                for (int i = 0; i < 30; i++) begin
                    repeat ($urandom_range(0, 3)) @(negedge clk);
                    enviar(0, 4'($urandom), 8'h00, 1'($urandom_range(0, 1)), ff);
                end
            end
            begin : rama1
                enviar(1, 4'b1011, 8'h00, 0, ff);
                repeat (12) @(negedge clk);
                comprobar("T4_ocupado", listo_s[1], 0);
                valido[1] = 1'b1;
                dato[1] = 4'b1111;
                @(negedge clk);
                valido[1] = 1'b0;
                enviar(1, 4'b1111, 8'h00, 0, ff);
                comprobar("T4_b2b_en_fin", ff, 1);
                comprobar("T4_palabra2", pal_s[1], 8'hFF);
                repeat (50) @(negedge clk);
                enviar(1, 4'b0110, 8'h00, 0, ff);
                repeat (17) @(negedge clk);
                abortar[1] = 1;
                rst[1] = 1'b1;
                @(negedge clk);
                rst[1] = 1'b0;
                comprobar("T5_tx", tx_s[1], 1);
                comprobar("T5_listo", listo_s[1], 1);
                comprobar("T5_activo", act_s[1], 0);
                comprobar("T5_fin", fin_s[1], 0);
                comprobar("T5_palabra", pal_s[1], 8'h00);
                repeat (45) @(negedge clk);
                comprobar("T5_abort_visto", abortar[1], 0);
                enviar(1, 4'b1001, 8'h00, 0, ff);
                for (int i = 0; i < 15; i++) begin
                    repeat ($urandom_range(0, 3)) @(negedge clk);
                    enviar(1, 4'($urandom), 8'h00, 1'($urandom_range(0, 1)), ff);
                end
            end
        join

        repeat (60) @(negedge clk);
        comprobar("cola0_vacia", esp0.size(), 0);
        comprobar("cola1_vacia", esp1.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fallos);
        $finish;
    end

endmodule
